// File: rtl/banked_frame_memory.sv
// Single-port, lane-banked frame/command memory with per-lane write masking and a zero-fill clear engine.
// Optional build macro FRAME_MEM_PARITY_EN adds one stored even-parity bit per lane and drives ParityErr.
module banked_frame_memory #(
  parameter int NUM_LANES = 12,
  parameter int LANE_W    = 8,
  parameter int ADDR_W    = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        CS_bar,
  input  logic                        WE_bar,
  input  logic [ADDR_W-1:0]           Address,
  input  logic [NUM_LANES-1:0]        WrMask,
  input  logic [NUM_LANES*LANE_W-1:0] DataIn,
  output logic [NUM_LANES*LANE_W-1:0] DataOut,
  output logic                        RdValid,
  input  logic                        ClearStart,
  output logic                        Busy,
  output logic                        ClearDone,
  output logic                        ParityErr
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int DATA_W = NUM_LANES * LANE_W;
  localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W:0]   clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              ext_access;
  logic              ext_wr;
  logic              ext_rd;
  logic              clr_wr;
  logic [ADDR_W-1:0] clr_addr;

  // An access coinciding with a clear request is dropped, as is everything while clearing.
  assign ext_access = (state == IDLE) && !CS_bar && !ClearStart;
  assign ext_wr     = ext_access && !WE_bar;
  assign ext_rd     = ext_access && WE_bar;
  assign clr_wr     = (state == CLEAR);
  assign clr_addr   = clr_cnt[ADDR_W-1:0];

`ifdef FRAME_MEM_PARITY_EN
  logic [NUM_LANES-1:0] par_mem [DEPTH];
  logic [NUM_LANES-1:0] wr_par;
  logic [NUM_LANES-1:0] rd_mismatch;

  always_comb begin
    wr_par      = '0;
    rd_mismatch = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      wr_par[i]      = ^DataIn[i*LANE_W +: LANE_W];
      rd_mismatch[i] = (^mem[Address][i*LANE_W +: LANE_W]) ^ par_mem[Address][i];
    end
  end
`endif

  // Array writes are blocked during reset so a reset mid-clear leaves the current word untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_wr) begin
        mem[clr_addr] <= '0;
`ifdef FRAME_MEM_PARITY_EN
        par_mem[clr_addr] <= '0;
`endif
      end else if (ext_wr) begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
          if (WrMask[i]) begin
            mem[Address][i*LANE_W +: LANE_W] <= DataIn[i*LANE_W +: LANE_W];
`ifdef FRAME_MEM_PARITY_EN
            par_mem[Address][i] <= wr_par[i];
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      clr_cnt   <= '0;
      Busy      <= 1'b0;
      ClearDone <= 1'b0;
      RdValid   <= 1'b0;
      DataOut   <= '0;
`ifdef FRAME_MEM_PARITY_EN
      ParityErr <= 1'b0;
`endif
    end else begin
      ClearDone <= 1'b0;
      RdValid   <= 1'b0;
`ifdef FRAME_MEM_PARITY_EN
      ParityErr <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (ClearStart) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            Busy    <= 1'b1;
          end else if (ext_rd) begin
            DataOut <= mem[Address];
            RdValid <= 1'b1;
`ifdef FRAME_MEM_PARITY_EN
            ParityErr <= |rd_mismatch;
`endif
          end
        end
        CLEAR: begin
          if (clr_cnt == LAST_WORD) begin
            state     <= IDLE;
            Busy      <= 1'b0;
            ClearDone <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef FRAME_MEM_PARITY_EN
  assign ParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_banked_frame_memory.sv
// Directed self-checking bench for banked_frame_memory (default 12x8-bit lanes, 8 words).
// The parity-corruption scenario runs only when FRAME_MEM_PARITY_EN is defined.
module tb_banked_frame_memory;

  localparam int NUM_LANES = 12;
  localparam int LANE_W    = 8;
  localparam int ADDR_W    = 3;
  localparam int DATA_W    = NUM_LANES * LANE_W;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 CS_bar;
  logic                 WE_bar;
  logic [ADDR_W-1:0]    Address;
  logic [NUM_LANES-1:0] WrMask;
  logic [DATA_W-1:0]    DataIn;
  logic [DATA_W-1:0]    DataOut;
  logic                 RdValid;
  logic                 ClearStart;
  logic                 Busy;
  logic                 ClearDone;
  logic                 ParityErr;

  int n_checks = 0;
  int n_errors = 0;

  banked_frame_memory #(
    .NUM_LANES(NUM_LANES),
    .LANE_W   (LANE_W),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .CS_bar    (CS_bar),
    .WE_bar    (WE_bar),
    .Address   (Address),
    .WrMask    (WrMask),
    .DataIn    (DataIn),
    .DataOut   (DataOut),
    .RdValid   (RdValid),
    .ClearStart(ClearStart),
    .Busy      (Busy),
    .ClearDone (ClearDone),
    .ParityErr (ParityErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rep(input logic [LANE_W-1:0] b);
    return {NUM_LANES{b}};
  endfunction

  task automatic idle();
    CS_bar     = 1'b1;
    WE_bar     = 1'b1;
    ClearStart = 1'b0;
    WrMask     = '0;
    DataIn     = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [NUM_LANES-1:0] m,
                          input logic [DATA_W-1:0] d);
    CS_bar = 1'b0; WE_bar = 1'b0; Address = a; WrMask = m; DataIn = d;
    tick();
    idle();
    check($sformatf("wr_rdvalid_a%0d", a), {95'd0, RdValid}, '0);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp,
                         input logic exp_perr);
    CS_bar = 1'b0; WE_bar = 1'b1; Address = a;
    tick();
    idle();
    check($sformatf("rd_valid_a%0d", a), {95'd0, RdValid}, 96'd1);
    check($sformatf("rd_data_a%0d", a), DataOut, exp);
    check($sformatf("rd_perr_a%0d", a), {95'd0, ParityErr}, {95'd0, exp_perr});
  endtask

  initial begin
    logic [DATA_W-1:0] exp;
    rst = 1'b1;
    Address = '0;
    idle();
    tick();
    tick();
    check("rst_dataout", DataOut, '0);
    check("rst_rdvalid", {95'd0, RdValid}, '0);
    check("rst_busy", {95'd0, Busy}, '0);
    check("rst_cleardone", {95'd0, ClearDone}, '0);
    check("rst_perr", {95'd0, ParityErr}, '0);
    rst = 1'b0;
    tick();

    // Full write then read, RdValid is a single-cycle pulse
    do_write(3'd3, 12'hFFF, rep(8'hA5));
    do_read(3'd3, rep(8'hA5), 1'b0);
    tick();
    check("rdvalid_pulse_end", {95'd0, RdValid}, '0);
    check("dataout_hold", DataOut, rep(8'hA5));

    // Masked write: lanes 0 and 2 only
    do_write(3'd3, 12'h005, rep(8'h3C));
    do_read(3'd3, 96'hA5A5A5A5A5A5A5A5A53CA53C, 1'b0);

    for (int i = 0; i < 8; i++) do_write(ADDR_W'(i), 12'hFFF, rep(8'h10 + 8'(i)));

    // Back-to-back reads, one-cycle latency
    CS_bar = 1'b0; WE_bar = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Address = ADDR_W'(i);
      tick();
      check($sformatf("b2b_valid_%0d", i), {95'd0, RdValid}, 96'd1);
      check($sformatf("b2b_data_%0d", i), DataOut, rep(8'h10 + 8'(i)));
    end
    idle();
    tick();
    check("b2b_valid_end", {95'd0, RdValid}, '0);

    // Clear with an ignored write on the start cycle and ignored traffic while busy
    ClearStart = 1'b1; CS_bar = 1'b0; WE_bar = 1'b0; Address = 3'd6; WrMask = 12'hFFF;
    DataIn = rep(8'hEE);
    tick();
    for (int k = 0; k < 8; k++) begin
      check($sformatf("clr_busy_%0d", k), {95'd0, Busy}, 96'd1);
      check($sformatf("clr_done_lo_%0d", k), {95'd0, ClearDone}, '0);
      check($sformatf("clr_rdvalid_%0d", k), {95'd0, RdValid}, '0);
      check($sformatf("clr_dout_hold_%0d", k), DataOut, rep(8'h12));
      if (k == 2) ClearStart = 1'b0;
      CS_bar = 1'b0; Address = 3'd0; WrMask = 12'hFFF; DataIn = rep(8'hFF);
      WE_bar = (k < 6) ? 1'b1 : 1'b0;
      tick();
    end
    idle();
    check("clr_busy_end", {95'd0, Busy}, '0);
    check("clr_done_pulse", {95'd0, ClearDone}, 96'd1);
    tick();
    check("clr_done_end", {95'd0, ClearDone}, '0);
    for (int i = 0; i < 8; i++) do_read(ADDR_W'(i), '0, 1'b0);

    // Reset after four clear writes: words 0-3 zeroed, 4-7 retained
    for (int i = 0; i < 8; i++) do_write(ADDR_W'(i), 12'hFFF, rep(8'h50 + 8'(i)));
    ClearStart = 1'b1;
    tick();
    ClearStart = 1'b0;
    repeat (4) tick();
    check("rstclr_busy_before", {95'd0, Busy}, 96'd1);
    rst = 1'b1;
    tick();
    check("rstclr_busy", {95'd0, Busy}, '0);
    check("rstclr_done", {95'd0, ClearDone}, '0);
    check("rstclr_dout", DataOut, '0);
    rst = 1'b0;
    tick();
    check("rstclr_done_after", {95'd0, ClearDone}, '0);
    check("rstclr_busy_after", {95'd0, Busy}, '0);
    for (int i = 0; i < 8; i++) do_read(ADDR_W'(i), (i < 4) ? '0 : rep(8'h50 + 8'(i)), 1'b0);

    // Parity: corrupt one stored bit when the parity build is active
    do_write(3'd1, 12'hFFF, rep(8'h77));
    exp = rep(8'h77);
`ifdef FRAME_MEM_PARITY_EN
    dut.mem[1][0] = ~dut.mem[1][0];
    exp[0] = 1'b0;
    do_read(3'd1, exp, 1'b1);
    tick();
    check("perr_low_no_read", {95'd0, ParityErr}, '0);
`else
    do_read(3'd1, exp, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
